// File: rtl/gate_array_pkg.sv
// Shared types for the gate array pipeline.
// Gate select encoding and its width.
package gate_array_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NOTA = 3'd6,
        OP_PASS = 3'd7
    } op_t;

endpackage

// File: rtl/gate_array_alu.sv
// Combinational bitwise gate selected by op_t.
// Operand B is ignored for NOT A and PASS A.
module gate_array_alu
    import gate_array_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  op_t              i_op,
    output logic [WIDTH-1:0] o_res
);

    always_comb begin
        o_res = '0;
        unique case (i_op)
            OP_AND:  o_res = i_a & i_b;
            OP_OR:   o_res = i_a | i_b;
            OP_XOR:  o_res = i_a ^ i_b;
            OP_NAND: o_res = ~(i_a & i_b);
            OP_NOR:  o_res = ~(i_a | i_b);
            OP_XNOR: o_res = ~(i_a ^ i_b);
            OP_NOTA: o_res = ~i_a;
            OP_PASS: o_res = i_a;
        endcase
    end

endmodule

// File: rtl/gate_array_pipe.sv
// Two-stage valid/ready gate pipeline with zero/ones/parity flags.
// Define GATE_ARRAY_CNT_EN to enable the accepted-transaction counter.
module gate_array_pipe
    import gate_array_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OP_W-1:0]  in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_zero,
    output logic             out_ones,
    output logic             out_par,
    output logic [CNT_W-1:0] out_cnt
);

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_res;
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_res;
    logic             r_zero;
    logic             r_ones;
    logic             r_par;

    logic             w_adv1;
    logic             w_adv2;
    logic [WIDTH-1:0] w_alu;

    // Ready ripples back combinationally so a full pipe still streams
    assign w_adv2   = !r_s2_valid || out_ready;
    assign w_adv1   = !r_s1_valid || w_adv2;
    assign in_ready = w_adv1;

    gate_array_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .i_a   (in_a),
        .i_b   (in_b),
        .i_op  (op_t'(in_op)),
        .o_res (w_alu)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_res   <= '0;
        end else if (w_adv1) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_res <= w_alu;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_res   <= '0;
            r_zero     <= 1'b0;
            r_ones     <= 1'b0;
            r_par      <= 1'b0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_res <= r_s1_res;
                r_zero   <= (r_s1_res == '0);
                r_ones   <= &r_s1_res;
                r_par    <= ^r_s1_res;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_res   = r_s2_res;
    assign out_zero  = r_zero;
    assign out_ones  = r_ones;
    assign out_par   = r_par;

`ifdef GATE_ARRAY_CNT_EN
    logic             w_in_fire;
    logic [CNT_W-1:0] r_cnt;

    assign w_in_fire = in_valid && w_adv1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_in_fire) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign out_cnt = r_cnt;
`else
    assign out_cnt = '0;
`endif

endmodule

// File: tb/tb_gate_array_pipe.sv
// Directed and randomized bench for gate_array_pipe (WIDTH=8).
// Counter expectations follow GATE_ARRAY_CNT_EN.
module tb_gate_array_pipe;

    localparam int WIDTH = 8;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_res;
    logic             out_zero;
    logic             out_ones;
    logic             out_par;
    logic [CNT_W-1:0] out_cnt;

    int checks = 0;
    int errors = 0;
    int n_acc = 0;
    int n_del = 0;
    bit f_in;
    bit f_out;
    logic [10:0] q[$];

    gate_array_pipe #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_zero  (out_zero),
        .out_ones  (out_ones),
        .out_par   (out_par),
        .out_cnt   (out_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gate(input logic [7:0] a,
                                        input logic [7:0] b,
                                        input logic [2:0] op);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a & b);
            3'd4:    return ~(a | b);
            3'd5:    return ~(a ^ b);
            3'd6:    return ~a;
            default: return a;
        endcase
    endfunction

    // {res, zero, ones, par}
    function automatic logic [10:0] pack(input logic [7:0] r);
        return {r, r == 8'h00, r == 8'hFF, ^r};
    endfunction

    function automatic logic [15:0] exp_cnt(input int n);
`ifdef GATE_ARRAY_CNT_EN
        return 16'(n);
`else
        return (n < 0) ? 16'hFFFF : 16'h0000;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample handshakes just before the edge, then advance one cycle
    task automatic tick();
        #1;
        f_in  = in_valid && in_ready;
        f_out = out_valid && out_ready;
        if (f_out) begin
            chk("sb_nonempty", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                chk("sb_data", {21'd0, out_res, out_zero, out_ones, out_par},
                    {21'd0, q[0]});
                void'(q.pop_front());
                n_del++;
            end
        end
        if (f_in) begin
            q.push_back(pack(gate(in_a, in_b, in_op)));
            n_acc++;
        end
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_ops [8];
    logic [7:0] fa [3];
    logic [7:0] fb [3];
    logic [2:0] fo [3];
    logic [10:0] fx [3];
    logic [7:0] held;
    int acc0;
    int idx;
    int sent;
    int cyc;

    initial begin
        exp_ops = '{8'h42, 8'hDB, 8'h99, 8'hBD, 8'h24, 8'h66, 8'h3C, 8'hC3};
        fa = '{8'h00, 8'hFF, 8'h01};
        fb = '{8'hFF, 8'h00, 8'h00};
        fo = '{3'd0, 3'd1, 3'd2};
        fx = '{{8'h00, 3'b100}, {8'hFF, 3'b010}, {8'h01, 3'b001}};

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_op = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_res", 32'(out_res), 32'd0);
        chk("rst_cnt", 32'(out_cnt), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        // All ops back-to-back: result k appears two cycles after drive
        for (int i = 0; i < 10; i++) begin
            chk("lat_valid", 32'(out_valid), (i >= 2) ? 32'd1 : 32'd0);
            if (i >= 2) chk("op_res", 32'(out_res), 32'(exp_ops[i-2]));
            in_valid = (i < 8);
            in_a = 8'hC3;
            in_b = 8'h5A;
            in_op = 3'(i);
            tick();
        end
        in_valid = 1'b0;
        repeat (2) tick();

        for (int i = 0; i < 5; i++) begin
            if (i >= 2) chk("flags",
                {21'd0, out_res, out_zero, out_ones, out_par},
                {21'd0, fx[i-2]});
            in_valid = (i < 3);
            if (i < 3) begin
                in_a = fa[i];
                in_b = fb[i];
                in_op = fo[i];
            end
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        chk("idle_empty", 32'(q.size()), 32'd0);

        // Backpressure with a continuous stream
        out_ready = 1'b0;
        acc0 = n_acc;
        idx = 0;
        in_valid = 1'b1;
        in_op = 3'd2;
        in_b = 8'h0F;
        in_a = 8'h10;
        held = gate(8'h10, 8'h0F, 3'd2);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (f_in) begin
                idx++;
                in_a = 8'(8'h10 + idx);
            end
            if (i >= 2) chk("bp_stable", 32'(out_res), 32'(held));
        end
        chk("bp_accepts", 32'(n_acc - acc0), 32'd2);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 12 && idx < 6; i++) begin
            tick();
            if (f_in) begin
                idx++;
                in_a = 8'(8'h10 + idx);
            end
        end
        in_valid = 1'b0;
        repeat (4) tick();
        chk("bp_drained", 32'(q.size()), 32'd0);
        chk("bp_idle", 32'(out_valid), 32'd0);
        chk("cnt_mid", 32'(out_cnt), 32'(exp_cnt(n_acc)));

        // Fill both stages, then reset mid-cycle
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_a = 8'hAA;
        repeat (3) tick();
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_res", 32'(out_res), 32'd0);
        chk("arst_cnt", 32'(out_cnt), 32'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        n_acc = 0;
        n_del = 0;

        // Random valid/ready, payload held until accepted
        sent = 0;
        cyc = 0;
        f_in = 1'b0;
        in_valid = 1'b0;
        while ((sent < 1000 || q.size() != 0) && cyc < 20000) begin
            if (!in_valid || f_in) begin
                in_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
                in_a = 8'($urandom);
                in_b = 8'($urandom);
                in_op = 3'($urandom_range(0, 7));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (f_in) sent++;
            if (sent >= 1000 && f_in) in_valid = 1'b0;
            cyc++;
        end
        in_valid = 1'b0;
        chk("rand_done", 32'(cyc < 20000), 32'd1);
        chk("rand_delivered", 32'(n_del), 32'd1000);
        chk("rand_cnt", 32'(out_cnt), 32'(exp_cnt(1000)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
